// File: rtl/vector_load_store_engine.sv
`default_nettype none
// ============================================================================
//  Module   : vector_load_store_engine
//  Purpose  : Serialises one scalar/vector (gather-scatter or strided) memory
//             request into single-word data-cache accesses.
//  Revision : 1.0  initial release
// ============================================================================
module vector_load_store_engine #(
    parameter int LANES  = 4,
    parameter int WORD_W = 32
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic                             req_vector,
    input  logic                             req_strided,
    input  logic [LANES-1:0]                 req_mask,
    input  logic [LANES-1:0][WORD_W-1:0]     req_addr,
    input  logic [WORD_W-1:0]                req_stride,
    input  logic [LANES-1:0][WORD_W-1:0]     req_store,
    output logic                             dmemREN,
    output logic                             dmemWEN,
    output logic [WORD_W-1:0]                dmemaddr,
    output logic [WORD_W-1:0]                dmemstore,
    input  logic [WORD_W-1:0]                dmemload,
    input  logic                             dcacheHit,
    output logic                             done,
    output logic [LANES-1:0][WORD_W-1:0]     vdload,
    output logic                             busy
);

    localparam int IDX_W = $clog2(LANES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]                     r_state;
    logic [1:0]                     w_state_nxt;
    logic                           r_write;
    logic                           r_strided;
    logic [LANES-1:0]               r_mask;
    logic [LANES-1:0][WORD_W-1:0]   r_addr;
    logic [LANES-1:0][WORD_W-1:0]   r_store;
    logic [LANES-1:0][WORD_W-1:0]   r_vdload;
    logic [WORD_W-1:0]              r_stride;
    logic [IDX_W-1:0]               r_idx;
    logic [IDX_W-1:0]               w_idx_nxt;
    logic [IDX_W-1:0]               w_first_idx;
    logic                           w_more;
    logic [LANES-1:0]               w_eff_mask;
    logic                           w_accept;
    logic                           w_access;
    logic [WORD_W-1:0]              w_offset;
    logic [WORD_W-1:0]              w_addr;

    // Scalar requests always act on lane 0 alone, whatever req_mask says.
    assign w_eff_mask = req_vector ? req_mask : {{(LANES-1){1'b0}}, 1'b1};
    assign w_accept   = (r_state == S_IDLE) && req_valid;
    assign w_access   = (r_state == S_ACCESS);

    always_comb begin
        w_first_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_eff_mask[i]) w_first_idx = IDX_W'(i);
        end
    end

    // Lowest active lane strictly above the current one; none means last lane.
    always_comb begin
        w_idx_nxt = r_idx;
        w_more    = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_idx))) begin
                w_idx_nxt = IDX_W'(i);
                w_more    = 1'b1;
            end
        end
    end

    assign w_offset = r_stride * WORD_W'(r_idx);
    assign w_addr   = r_strided ? (r_addr[0] + w_offset) : r_addr[r_idx];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (req_valid) w_state_nxt = (|w_eff_mask) ? S_ACCESS : S_DONE;
            S_ACCESS: if (dcacheHit && !w_more) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_strided <= 1'b0;
            r_mask    <= '0;
            r_addr    <= '0;
            r_store   <= '0;
            r_stride  <= '0;
            r_idx     <= '0;
            r_vdload  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_write   <= req_write;
                r_strided <= req_vector && req_strided;
                r_mask    <= w_eff_mask;
                r_addr    <= req_addr;
                r_store   <= req_store;
                r_stride  <= req_stride;
                r_idx     <= w_first_idx;
            end else if (w_access && dcacheHit) begin
                if (!r_write) r_vdload[r_idx] <= dmemload;
                r_idx <= w_idx_nxt;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign dmemREN   = w_access && !r_write;
    assign dmemWEN   = w_access && r_write;
    assign dmemaddr  = w_access ? w_addr : '0;
    assign dmemstore = w_access ? r_store[r_idx] : '0;
    assign vdload    = r_vdload;

endmodule
`default_nettype wire

// File: tb/tb_vector_load_store_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_load_store_engine
//  Purpose  : Table-driven, scoreboarded bench for vector_load_store_engine.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vector_load_store_engine;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_write = 1'b0;
    logic               req_vector = 1'b0;
    logic               req_strided = 1'b0;
    logic [3:0]         req_mask = '0;
    logic [3:0][31:0]   req_addr = '0;
    logic [31:0]        req_stride = '0;
    logic [3:0][31:0]   req_store = '0;
    logic               dmemREN;
    logic               dmemWEN;
    logic [31:0]        dmemaddr;
    logic [31:0]        dmemstore;
    logic [31:0]        dmemload;
    logic               dcacheHit = 1'b0;
    logic               done;
    logic [3:0][31:0]   vdload;
    logic               busy;

    vector_load_store_engine #(.LANES(4), .WORD_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_vector(req_vector), .req_strided(req_strided),
        .req_mask(req_mask), .req_addr(req_addr), .req_stride(req_stride),
        .req_store(req_store),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dmemload(dmemload), .dcacheHit(dcacheHit),
        .done(done), .vdload(vdload), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string              name;
        bit                 wr, vec, str;
        logic [3:0]         mask;
        logic [3:0][31:0]   addr;
        logic [31:0]        stride;
        logic [3:0][31:0]   store;
        int                 delay;
        bit                 fhit;
        logic [3:0][31:0]   exp_addr;
        int                 exp_lat;
    } vec_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t             sb[$];
    logic [3:0][31:0] exp_vd = '0;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               cur_delay = 0;
    int               stall_cnt = 0;
    bit               force_hit = 1'b0;
    vec_t             tbl[7];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0F0F) + 32'h1357);
    endfunction

    assign dmemload = memfn(dmemaddr);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Cache model: hit after cur_delay stall cycles; every access cycle is checked
    // against the head of the scoreboard, which is popped on the hit.
    always @(negedge CLK) begin
        if (dmemREN || dmemWEN) begin
            logic hit;
            hit = (stall_cnt >= cur_delay);
            if (sb.size() == 0) begin
                chk("unexpected_access", {dmemWEN, dmemREN, dmemaddr}, 128'h0);
            end else begin
                chk("access", {dmemWEN, dmemREN, dmemaddr, (dmemWEN ? dmemstore : 32'h0)},
                    {sb[0].wr, !sb[0].wr, sb[0].addr, (sb[0].wr ? sb[0].data : 32'h0)});
                if (hit) void'(sb.pop_front());
            end
            stall_cnt = hit ? 0 : stall_cnt + 1;
            dcacheHit = hit;
        end else begin
            stall_cnt = 0;
            dcacheHit = force_hit;
        end
    end

    function automatic vec_t mk(input string name, input bit wr, vec, str, input logic [3:0] mask,
                                input logic [3:0][31:0] addr, input logic [31:0] stride,
                                input logic [3:0][31:0] store, input int delay, input bit fhit,
                                input logic [3:0][31:0] exp_addr, input int exp_lat);
        vec_t v;
        v.name = name; v.wr = wr; v.vec = vec; v.str = str; v.mask = mask;
        v.addr = addr; v.stride = stride; v.store = store; v.delay = delay;
        v.fhit = fhit; v.exp_addr = exp_addr; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic push_exp(input vec_t v);
        logic [3:0] em;
        em = v.vec ? v.mask : 4'b0001;
        for (int i = 0; i < 4; i++) begin
            if (em[i]) begin
                sb.push_back({v.wr, v.exp_addr[i], v.store[i]});
                if (!v.wr) exp_vd[i] = memfn(v.exp_addr[i]);
            end
        end
        cur_delay = v.delay;
        force_hit = v.fhit;
    endtask

    task automatic drive(input vec_t v);
        req_write = v.wr; req_vector = v.vec; req_strided = v.str; req_mask = v.mask;
        req_addr = v.addr; req_stride = v.stride; req_store = v.store; req_valid = 1'b1;
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        int cyc;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!done && cyc < 300);
        chk({name, "_latency"}, {done, 32'(cyc)}, {1'b1, 32'(exp_lat)});
        @(negedge CLK);
        chk({name, "_pulse_end"}, {done, req_ready, busy}, {1'b0, 1'b1, 1'b0});
        chk({name, "_sb_empty"}, 128'(sb.size()), 128'h0);
        chk({name, "_vdload"}, vdload, exp_vd);
    endtask

    task automatic run_req(input vec_t v);
        @(posedge CLK); #1;
        push_exp(v);
        drive(v);
        @(posedge CLK); #1;
        req_valid = 1'b0;
        wait_done(v.exp_lat, v.name);
    endtask

    initial begin
        vec_t a, b;
        tbl[0] = mk("scalar_load", 0, 0, 0, 4'b1110, {32'hBAD3, 32'hBAD2, 32'hBAD1, 32'h100}, 32'h0,
                    '0, 0, 0, {32'h0, 32'h0, 32'h0, 32'h100}, 2);
        tbl[1] = mk("gather_load", 0, 1, 0, 4'b1011, {32'h40, 32'h30, 32'h20, 32'h10}, 32'h0,
                    '0, 2, 0, {32'h40, 32'h30, 32'h20, 32'h10}, 10);
        tbl[2] = mk("strided_store", 1, 1, 1, 4'b1111, {32'hBAD3, 32'hBAD2, 32'hBAD1, 32'h1000},
                    32'hFFFF_FFFC, {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000},
                    0, 0, {32'hFF4, 32'hFF8, 32'hFFC, 32'h1000}, 5);
        tbl[3] = mk("empty_mask", 0, 1, 0, 4'b0000, {32'h4, 32'h3, 32'h2, 32'h1}, 32'h0,
                    '0, 0, 1, '0, 1);
        tbl[4] = mk("strided_last_lane", 0, 1, 1, 4'b1000, {32'hBAD3, 32'hBAD2, 32'hBAD1, 32'h200},
                    32'h8, '0, 1, 0, {32'h218, 32'h0, 32'h0, 32'h0}, 3);
        tbl[5] = mk("scalar_store", 1, 0, 0, 4'b1111, {32'h0, 32'h0, 32'h0, 32'h300}, 32'h0,
                    {32'h0, 32'h0, 32'h0, 32'hCAFE_F00D}, 3, 0, {32'h0, 32'h0, 32'h0, 32'h300}, 5);
        tbl[6] = mk("gather_mid", 0, 1, 0, 4'b0110, {32'h6C, 32'h68, 32'h64, 32'h60}, 32'h0,
                    '0, 0, 0, {32'h6C, 32'h68, 32'h64, 32'h60}, 3);

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("reset_ctrl", {req_ready, busy, done, dmemREN, dmemWEN, dmemaddr, dmemstore},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
        chk("reset_vdload", vdload, 128'h0);

        for (int i = 0; i < 7; i++) run_req(tbl[i]);

        // Reset while lane 1 of a four-lane load is in flight
        a = mk("reset_victim", 0, 1, 0, 4'b1111, {32'h7C, 32'h78, 32'h74, 32'h70}, 32'h0,
               '0, 0, 0, {32'h7C, 32'h78, 32'h74, 32'h70}, 5);
        @(posedge CLK); #1;
        push_exp(a);
        drive(a);
        @(posedge CLK); #1 req_valid = 1'b0;
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        sb.delete();
        exp_vd = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("midreset_ctrl", {req_ready, busy, done, dmemREN, dmemWEN, dmemaddr, dmemstore},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
        end
        chk("midreset_vdload", vdload, 128'h0);
        run_req(tbl[0]);

        // req_valid held high with a different request while busy
        a = mk("hold_first", 0, 0, 0, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h400}, 32'h0,
               '0, 1, 0, {32'h0, 32'h0, 32'h0, 32'h400}, 3);
        b = mk("hold_second", 1, 1, 0, 4'b0011, {32'h0, 32'h0, 32'h504, 32'h500}, 32'h0,
               {32'h0, 32'h0, 32'hB0B1, 32'hA0A1}, 0, 0, {32'h0, 32'h0, 32'h504, 32'h500}, 3);
        @(posedge CLK); #1;
        push_exp(a);
        drive(a);
        @(posedge CLK); #1;
        drive(b);
        wait_done(a.exp_lat, a.name);
        push_exp(b);
        @(posedge CLK); #1 req_valid = 1'b0;
        wait_done(b.exp_lat, b.name);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_load_store_engine.md
Name: vector_load_store_engine

Overview:
- Parametrised successor to the per-thread vector load/store sequencer.
- Accepts one scalar or vector memory request from the execute stage and serialises it into single-word data-cache accesses.
- Vector requests carry a per-lane active mask and use either gather/scatter (per-lane addresses) or strided addressing (base + lane*stride).
- Sits between the SIMT execute stage and the data cache; reports completion with a one-cycle done pulse and a lane-indexed load result.

Parameters:
LANES, 4, number of vector lanes (power of two, >= 2)
WORD_W, 32, data and address width in bits

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  engine can accept a request (IDLE only)
req_write  in  1  1 = store, 0 = load
req_vector  in  1  1 = vector, 0 = scalar (lane 0 only)
req_strided  in  1  vector only: 1 = strided, 0 = gather/scatter
req_mask  in  LANES  per-lane active bits (ignored for scalar)
req_addr  in  LANES x WORD_W  per-lane addresses; lane 0 is base/scalar address
req_stride  in  WORD_W  byte stride for strided mode
req_store  in  LANES x WORD_W  per-lane store data
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  WORD_W  cache address
dmemstore  out  WORD_W  cache store data
dmemload  in  WORD_W  cache load data
dcacheHit  in  1  access completes this cycle
done  out  1  one-cycle completion pulse
vdload  out  LANES x WORD_W  load results, lane-indexed
busy  out  1  request in flight (not IDLE)

Behaviour:
- States: IDLE, ACCESS, DONE. Reset leaves the engine in IDLE.
- Reset values: req_ready=1, busy=0, done=0, dmemREN=0, dmemWEN=0, dmemaddr=0, dmemstore=0, all vdload lanes = 0.
- Reset mid-operation aborts the request on that edge and returns the engine to IDLE with the reset values above; no partial-completion done pulse is issued.
- IDLE: req_ready=1. On req_valid the engine latches all req_* fields (the request is captured).
  - Effective mask: scalar uses 1 on lane 0 only; vector uses req_mask.
  - Effective mask == 0 -> DONE next cycle, with no memory access.
  - Otherwise -> ACCESS, with lane index = lowest set bit of the effective mask.
- ACCESS:
  - dmemREN = !write, dmemWEN = write. Both are combinational from the state and never both 1.
  - dmemaddr: addr[idx] for scalar/gather; base + idx*stride for strided, computed modulo 2^WORD_W.
  - dmemstore = store[idx].
  - On dcacheHit: for a load, vdload[idx] <= dmemload. Then idx advances to the next set mask bit above idx.
  - If no set mask bit remains above idx -> DONE.
  - Without dcacheHit: hold address, data and enables unchanged (stall for any length).
- DONE: done=1 for exactly one cycle; enables are 0; -> IDLE.
- vdload rules:
  - Masked-off lanes retain their previous value (merge semantics).
  - Stores never modify vdload.
  - vdload is stable from DONE until the next load completes a lane.
- Latency: with k active lanes and a hit on every first cycle, done asserts k+1 cycles after the accept edge. With an empty mask it asserts 1 cycle after accept.
- Boundary conditions:
  - req_valid outside IDLE is ignored and not queued; req_ready=0 there.
  - dcacheHit outside ACCESS is ignored.
  - Lane LANES-1 as the last active lane ends the request without index wrap-around.
  - A new request may be accepted in the cycle after done.

Test Plan:
- Scalar load, addr[0]=0x100, cache returns 0xDEADBEEF on first cycle -> dmemaddr=0x100, REN for 1 cycle, done 2 cycles after accept, vdload[0]=0xDEADBEEF, other lanes unchanged.
- Vector gather load, mask=4'b1011, addrs 0x10/0x20/0x30/0x40, hit delayed 2 cycles each -> accesses 0x10, 0x20, 0x40 in order; vdload[2] keeps old value; done once.
- Strided store, base=0x1000, stride=0xFFFFFFFC (-4), mask=4'b1111 -> WEN addresses 0x1000, 0xFFC, 0xFF8, 0xFF4 with store[0..3]; vdload unchanged.
- Vector request with mask=0 -> no REN/WEN ever; done 1 cycle after accept.
- Assert RST during lane 1 of a 4-lane load -> next cycle IDLE, enables 0, vdload all 0, no done; a fresh request is then accepted normally.
- req_valid held high with a differing request while busy -> ignored; only the first request executes, and the second is accepted after done.
